// File: rtl/timestamp_pkg.sv
// timestamp_pkg: shared constants, record layout and helpers for the timestamp injector/extractor pair
package timestamp_pkg;
  localparam int BYTE = 8;
  localparam int PAYLOAD_OFFSET = 144;
  localparam int TIMESTAMP_SIZE = 96;
  localparam int NUM_SLOTS = 3;
  localparam logic [31:0] EMPTY_TIMESTAMP = 32'hDEADBEEF;
  localparam logic [15:0] VLAN_TPID = 16'h8100;
  typedef struct packed {
    logic [1:0]  slot;
    logic [31:0] nb_sync;
    logic [63:0] tick;
    logic [63:0] latency;
  } ts_rec_t;
  typedef enum logic {EM_IDLE, EM_EMIT} em_state_e;
  function automatic logic [31:0] count_ones(input logic [NUM_SLOTS-1:0] m);
    count_ones = '0;
    for (int i = 0; i < NUM_SLOTS; i++) count_ones += 32'(m[i]);
  endfunction
endpackage

// File: rtl/timestamp_extract_if.sv
// timestamp_extract_if: monitored 512-bit AXI-Stream bus and the record stream
interface ts_axis_if;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  modport master(output tvalid, tdata, tkeep, tlast, input tready);
  modport slave(input tvalid, tdata, tkeep, tlast, output tready);
  modport monitor(input tvalid, tready, tdata, tkeep, tlast);
endinterface

interface ts_rec_if;
  import timestamp_pkg::*;
  logic    tvalid;
  logic    tready;
  ts_rec_t tdata;
  modport master(output tvalid, tdata, input tready);
  modport slave(input tvalid, tdata, output tready);
endinterface

// File: rtl/ts_rec_fifo.sv
// ts_rec_fifo: synchronous record FIFO, head read from the register file, registered full/empty count
module ts_rec_fifo
  import timestamp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  ts_rec_t din_i,
  input  logic    pop_i,
  output ts_rec_t dout_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int AW = $clog2(DEPTH);
  ts_rec_t       mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= din_i;
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/timestamp_extract.sv
// timestamp_extract: spots sync packets on a monitored stream and emits one latency record per occupied slot
module timestamp_extract
  import timestamp_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [15:0] SYNC_ETHERTYPE = 16'h88F7
) (
  input  logic        axis_aclk,
  input  logic        axis_rst,
  ts_axis_if.monitor  s_axis,
  input  logic [63:0] curr_tick_i,
  ts_rec_if.master    m_rec,
  output logic [31:0] sync_pkt_count_o,
  output logic [31:0] rec_drop_count_o
);
  localparam int SB = TIMESTAMP_SIZE / BYTE;
  logic                                    in_pkt_q, in_pkt_d;
  logic [NUM_SLOTS-1:0]                    mask_q, mask_d, occ;
  logic [NUM_SLOTS-1:0][TIMESTAMP_SIZE-1:0] slot_q, slot_d, slot_in;
  logic [63:0]                             tick_q, tick_d;
  logic [31:0]                             sync_q, sync_d, drop_q, drop_d;
  em_state_e                               state_q, state_d;
  logic                                    beat, is_sync, push, full, empty;
  logic [1:0]                              sel;
  ts_rec_t                                 rec;
  for (genvar j = 0; j < NUM_SLOTS; j++) begin : g_slot
    localparam int HI  = 511 - PAYLOAD_OFFSET - TIMESTAMP_SIZE * j;
    localparam int KHI = 63 - PAYLOAD_OFFSET / BYTE - SB * j;
    assign slot_in[j] = s_axis.tdata[HI -: TIMESTAMP_SIZE];
    assign occ[j] = slot_in[j][95:64] != EMPTY_TIMESTAMP && &s_axis.tkeep[KHI -: SB];
  end
  assign beat    = s_axis.tvalid && s_axis.tready;
  assign is_sync = beat && !in_pkt_q && s_axis.tdata[511-12*BYTE -: 16] == VLAN_TPID &&
                   s_axis.tdata[511-16*BYTE -: 16] == SYNC_ETHERTYPE && &s_axis.tkeep[63 -: 18];
  always_comb begin
    sel      = mask_q[0] ? 2'd0 : mask_q[1] ? 2'd1 : 2'd2;
    push     = state_q == EM_EMIT && !full;
    in_pkt_d = beat ? !s_axis.tlast : in_pkt_q;
    mask_d   = push ? mask_q & ~(NUM_SLOTS'(1) << sel) : mask_q;
    slot_d   = slot_q;
    tick_d   = tick_q;
    // a new capture is only taken when nothing is pending; otherwise its records count as drops
    if (is_sync && mask_q == '0) begin
      mask_d = occ;
      slot_d = slot_in;
      tick_d = curr_tick_i;
    end
    sync_d      = sync_q + 32'(is_sync);
    drop_d      = drop_q + (is_sync && mask_q != '0 ? count_ones(occ) : 32'd0);
    state_d     = mask_d != '0 ? EM_EMIT : EM_IDLE;
    rec.slot    = sel;
    rec.nb_sync = slot_q[sel][95:64];
    rec.tick    = slot_q[sel][63:0];
    rec.latency = tick_q - slot_q[sel][63:0];
  end
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      in_pkt_q <= 1'b0;
      mask_q   <= '0;
      slot_q   <= '0;
      tick_q   <= '0;
      sync_q   <= '0;
      drop_q   <= '0;
      state_q  <= EM_IDLE;
    end else begin
      in_pkt_q <= in_pkt_d;
      mask_q   <= mask_d;
      slot_q   <= slot_d;
      tick_q   <= tick_d;
      sync_q   <= sync_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
    end
  end
  ts_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (axis_aclk),
    .rst    (axis_rst),
    .push_i (push),
    .din_i  (rec),
    .pop_i  (m_rec.tready),
    .dout_o (m_rec.tdata),
    .full_o (full),
    .empty_o(empty)
  );
  assign m_rec.tvalid     = !empty;
  assign sync_pkt_count_o = sync_q;
  assign rec_drop_count_o = drop_q;
endmodule

// File: tb/tb_timestamp_extract.sv
// tb_timestamp_extract: queue-based reference model plus directed and randomized sync traffic
module tb_timestamp_extract;
  import timestamp_pkg::*;
  localparam logic [31:0] E = 32'hDEADBEEF;
  logic        axis_aclk = 1'b0;
  logic        axis_rst = 1'b1;
  logic [63:0] curr_tick = '0;
  logic [31:0] sync_cnt, drop_cnt;
  ts_axis_if s_axis();
  ts_rec_if  m_rec();
  always #5 axis_aclk = ~axis_aclk;
  timestamp_extract #(.FIFO_DEPTH(8), .SYNC_ETHERTYPE(16'h88F7)) dut (
    .axis_aclk       (axis_aclk),
    .axis_rst        (axis_rst),
    .s_axis          (s_axis),
    .curr_tick_i     (curr_tick),
    .m_rec           (m_rec),
    .sync_pkt_count_o(sync_cnt),
    .rec_drop_count_o(drop_cnt)
  );
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] byte_at(input logic [511:0] d, input int b);
    return d[511-8*b -: 8];
  endfunction
  function automatic logic kept(input logic [63:0] k, input int lo, input int n);
    for (int b = lo; b < lo + n; b++) if (!k[63-b]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic [63:0] field(input logic [511:0] d, input int lo, input int n);
    logic [63:0] f = '0;
    for (int b = lo; b < lo + n; b++) f = {f[55:0], byte_at(d, b)};
    return f;
  endfunction
  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction
  function automatic logic [511:0] mk(input logic [15:0] et, input logic [95:0] s0, s1, s2);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
    d[415:400] = 16'h8100;
    d[383:368] = et;
    d[367:272] = s0;
    d[271:176] = s1;
    d[175:80]  = s2;
    return d;
  endfunction
  // reference model: captured-but-unpushed records, then the 8-deep FIFO
  ts_rec_t     eq[$], fq[$], nr[$];
  ts_rec_t     r;
  logic [31:0] m_sync = '0, m_drop = '0;
  logic [63:0] v;
  bit          m_in_pkt, armed, pop, push, busy, beat, sync;
  always @(posedge axis_aclk) begin
    if (axis_rst) begin
      eq.delete();
      fq.delete();
      m_sync   = '0;
      m_drop   = '0;
      m_in_pkt = 1'b0;
      armed    = 1'b1;
    end else begin
      busy = eq.size() != 0;
      pop  = fq.size() != 0 && m_rec.tready;
      push = busy && fq.size() < 8;
      beat = s_axis.tvalid && s_axis.tready;
      sync = beat && !m_in_pkt && field(s_axis.tdata, 12, 2) == 64'h8100 &&
             field(s_axis.tdata, 16, 2) == 64'h88F7 && kept(s_axis.tkeep, 0, 18);
      if (pop) void'(fq.pop_front());
      if (push) fq.push_back(eq.pop_front());
      if (sync) begin
        nr.delete();
        for (int j = 0; j < 3; j++) begin
          v = field(s_axis.tdata, 18 + 12 * j, 4);
          if (v[31:0] != E && kept(s_axis.tkeep, 18 + 12 * j, 12)) begin
            r.slot    = 2'(j);
            r.nb_sync = v[31:0];
            r.tick    = field(s_axis.tdata, 22 + 12 * j, 8);
            r.latency = curr_tick - r.tick;
            nr.push_back(r);
          end
        end
        m_sync++;
        if (busy) m_drop += 32'(nr.size());
        else eq = nr;
      end
      if (beat) m_in_pkt = !s_axis.tlast;
    end
  end
  ts_rec_t prev;
  bit      prev_stall;
  always @(negedge axis_aclk) begin
    if (armed && !axis_rst) begin
      chk("rec_tvalid", 192'(m_rec.tvalid), 192'(fq.size() != 0));
      if (fq.size() != 0) chk("rec_tdata", 192'(m_rec.tdata), 192'(fq[0]));
      chk("sync_count", 192'(sync_cnt), 192'(m_sync));
      chk("drop_count", 192'(drop_cnt), 192'(m_drop));
      if (prev_stall && m_rec.tvalid) chk("stable_tdata", 192'(m_rec.tdata), 192'(prev));
      prev_stall = m_rec.tvalid && !m_rec.tready;
      prev       = m_rec.tdata;
    end
  end
  task automatic drive(input logic vld, input logic [511:0] d, input logic [63:0] k, input logic l,
                       input logic [63:0] t);
    s_axis.tvalid = vld;
    s_axis.tdata  = d;
    s_axis.tkeep  = k;
    s_axis.tlast  = l;
    curr_tick     = t;
    @(posedge axis_aclk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, curr_tick + 64'd1);
  endtask
  initial begin
    logic [95:0] s[3];
    logic [63:0] k;
    s_axis.tready = 1'b1;
    m_rec.tready  = 1'b1;
    idle(3);
    chk("reset_tvalid", 192'(m_rec.tvalid), 192'(0));
    chk("reset_tdata", 192'(m_rec.tdata), 192'(0));
    chk("reset_sync", 192'(sync_cnt), 192'(0));
    chk("reset_drop", 192'(drop_cnt), 192'(0));
    axis_rst = 1'b0;
    idle(2);
    drive(1'b1, mk(16'h88F7, {32'd1, 64'd100}, {E, r64()}, {E, r64()}), '1, 1'b1, 64'd150);
    chk("single_tvalid_n1", 192'(m_rec.tvalid), 192'(0));
    chk("single_sync", 192'(sync_cnt), 192'(1));
    idle(1);
    chk("single_tvalid_n2", 192'(m_rec.tvalid), 192'(1));
    chk("single_rec", 192'(m_rec.tdata), 192'({2'd0, 32'd1, 64'd100, 64'd50}));
    idle(2);
    drive(1'b1, mk(16'h88F7, {E, r64()}, {32'd7, 64'hFFFF_FFFF_FFFF_FFF0}, {E, r64()}), '1, 1'b1, 64'd16);
    idle(1);
    chk("wrap_latency", 192'(m_rec.tdata.latency), 192'(32));
    chk("wrap_slot", 192'(m_rec.tdata.slot), 192'(1));
    idle(2);
    m_rec.tready = 1'b0;
    drive(1'b1, mk(16'h88F7, {32'd10, r64()}, {32'd11, r64()}, {32'd12, r64()}), '1, 1'b1, r64());
    idle(5);
    m_rec.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("order_slot", 192'(m_rec.tdata.slot), 192'(i));
      idle(1);
    end
    idle(2);
    m_rec.tready = 1'b0;
    drive(1'b1, mk(16'h88F7, {32'd20, r64()}, {32'd21, r64()}, {32'd22, r64()}), '1, 1'b1, r64());
    drive(1'b1, mk(16'h88F7, {32'd30, r64()}, {E, r64()}, {32'd32, r64()}), '1, 1'b1, r64());
    chk("overlap_drop", 192'(drop_cnt), 192'(2));
    idle(3);
    m_rec.tready = 1'b1;
    idle(6);
    chk("overlap_sync", 192'(sync_cnt), 192'(5));
    drive(1'b1, mk(16'h0800, {32'd40, r64()}, {32'd41, r64()}, {32'd42, r64()}), '1, 1'b0, r64());
    drive(1'b1, mk(16'h88F7, {32'd50, r64()}, {32'd51, r64()}, {32'd52, r64()}), '1, 1'b1, r64());
    idle(4);
    chk("nonsync_sync", 192'(sync_cnt), 192'(5));
    chk("nonsync_tvalid", 192'(m_rec.tvalid), 192'(0));
    m_rec.tready = 1'b0;
    drive(1'b1, mk(16'h88F7, {32'd60, r64()}, {32'd61, r64()}, {32'd62, r64()}), '1, 1'b1, r64());
    idle(2);
    axis_rst = 1'b1;
    idle(1);
    chk("rst_tvalid", 192'(m_rec.tvalid), 192'(0));
    chk("rst_tdata", 192'(m_rec.tdata), 192'(0));
    chk("rst_sync", 192'(sync_cnt), 192'(0));
    chk("rst_drop", 192'(drop_cnt), 192'(0));
    axis_rst = 1'b0;
    m_rec.tready = 1'b1;
    drive(1'b1, mk(16'h88F7, {32'd9, 64'd1000}, {E, r64()}, {E, r64()}), '1, 1'b1, 64'd1500);
    idle(1);
    chk("post_rst_rec", 192'(m_rec.tdata), 192'({2'd0, 32'd9, 64'd1000, 64'd500}));
    chk("post_rst_sync", 192'(sync_cnt), 192'(1));
    idle(2);
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 3; j++) s[j] = {($urandom_range(0, 2) == 0) ? E : 32'($urandom()), r64()};
      k = ($urandom_range(0, 2) == 0) ? ~64'd0 << $urandom_range(0, 50) : ~64'd0;
      s_axis.tready = $urandom_range(0, 3) != 0;
      m_rec.tready  = 1'($urandom_range(0, 1));
      drive($urandom_range(0, 3) != 0, mk(($urandom_range(0, 4) == 0) ? 16'h0800 : 16'h88F7, s[0], s[1], s[2]),
            k, $urandom_range(0, 2) == 0, r64());
    end
    s_axis.tready = 1'b1;
    m_rec.tready  = 1'b1;
    idle(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
